psram_arbiter: RTL and testbench
================================

PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter BURST_BEATS, default 8: number of 64-bit data beats per PSRAM command.
REQ-002 SHALL have parameter CMD_GAP, default 14: minimum idle cycles between the end of one command and the next o_cmd_en.
REQ-003 SHALL have parameter RD_TIMEOUT, default 64: maximum cycles from read issue to final read beat.
REQ-004 SHALL have parameter STARVE_MAX, default 4: maximum consecutive read grants while a write request is pending.
REQ-005 SHALL have these ports, clock and reset first (name  direction  width  meaning):
 i_clk  in  1  clock (PSRAM controller domain);
 i_rst_n  in  1  reset, asynchronous, active-low;
 i_calib_done  in  1  PSRAM controller initialised;
 i_w_req  in  1  writer request; i_w_addr  in  21  writer address;
 i_w_data  in  64  writer beat data; i_w_mask  in  8  writer beat byte mask (1 = masked);
 o_w_gnt  out  1  writer grant pulse;
 i_r_req  in  1  scan-out reader request; i_r_addr  in  21  reader address;
 o_r_gnt  out  1  reader grant pulse; o_r_data  out  64  read beat; o_r_valid  out  1  read beat valid;
 o_cmd  out  1  1 = write, 0 = read; o_cmd_en  out  1  command strobe; o_addr  out  21  command address;
 o_wr_data  out  64  write beat to controller; o_data_mask  out  8  write byte mask to controller;
 i_rd_data  in  64  controller read beat; i_rd_data_valid  in  1  controller read beat valid;
 o_busy  out  1  not in ST_IDLE; o_err  out  1  sticky read-timeout flag.

Function
REQ-006 SHALL implement states ST_INIT, ST_IDLE, ST_WR, ST_RD, ST_GAP.
REQ-007 ST_INIT SHALL ignore all requests and SHALL move to ST_IDLE on the first cycle i_calib_done = 1.
REQ-008 In ST_IDLE, a pending request SHALL produce a grant in the same cycle: o_cmd_en = 1, o_addr = the winner's address, and the winner's gnt = 1, all for exactly one cycle.
REQ-009 Arbitration SHALL give the reader priority, except that the writer SHALL win when the starvation counter equals STARVE_MAX.
REQ-010 The starvation counter SHALL increment on each read grant issued while i_w_req = 1, SHALL clear on each write grant, SHALL clear whenever i_w_req = 0 in ST_IDLE, and SHALL saturate at STARVE_MAX.
REQ-011 A write grant SHALL enter ST_WR with o_cmd = 1.
REQ-012 In ST_WR, o_wr_data and o_data_mask SHALL pass i_w_data and i_w_mask through combinationally for BURST_BEATS cycles, beat 0 being the grant cycle; ST_WR SHALL then move to ST_GAP.
REQ-013 Outside write-beat cycles, o_data_mask SHALL be 8'hFF and o_wr_data SHALL be 0.
REQ-014 A read grant SHALL enter ST_RD with o_cmd = 0.
REQ-015 In ST_RD, o_r_data = i_rd_data and o_r_valid = i_rd_data_valid combinationally; ST_RD SHALL count beats and SHALL move to ST_GAP after the BURST_BEATS-th beat.
REQ-016 If the beat count has not reached BURST_BEATS within RD_TIMEOUT cycles of the grant, ST_RD SHALL set o_err and move to ST_GAP.
REQ-017 Outside ST_RD, o_r_valid SHALL be 0 and i_rd_data_valid SHALL be ignored.
REQ-018 ST_GAP SHALL last exactly CMD_GAP cycles and then move to ST_IDLE; requests arriving during ST_GAP SHALL wait.
REQ-019 Requesters SHALL hold req and addr stable until gnt; the arbiter SHALL sample them only in ST_IDLE.
REQ-020 A requester dropping req before gnt SHALL NOT receive a grant; simultaneous requests SHALL follow REQ-009.
REQ-021 o_cmd SHALL hold its last value between commands.
REQ-022 o_err SHALL clear only on reset.

Reset
REQ-023 On i_rst_n = 0, the block SHALL asynchronously enter ST_INIT and clear all counters and o_err.
REQ-024 During reset, o_w_gnt, o_r_gnt, o_cmd_en, o_cmd, o_r_valid and o_err SHALL be 0, o_busy SHALL be 1, and o_data_mask SHALL be 8'hFF.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further grants or strobes; after release the block SHALL wait again for i_calib_done.

Verification
REQ-026 i_calib_done = 0 with both requests held -> no o_cmd_en; calib raised at cycle N -> read grant at cycle N+1.
REQ-027 Writer alone at address 0x00020, masks 0xFE..0x7F over 8 beats -> o_cmd = 1, o_addr = 0x00020, 8 beats forwarded, next o_cmd_en no earlier than 8+14 cycles after grant.
REQ-028 Both requests held continuously -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-029 Read with 8 valid beats interleaved with gaps -> 8 o_r_valid pulses with matching data, then ST_GAP; stray i_rd_data_valid in ST_IDLE -> o_r_valid stays 0.
REQ-030 Read with only 5 beats returned -> o_err = 1 at grant+64, block returns to ST_IDLE after 14 gap cycles.
REQ-031 Reset asserted at write beat 3 -> all outputs at reset values immediately; after release, wait for calib before the next grant.

Source files
------------

// File: rtl/psram_arbiter.sv
// Two-requester PSRAM command arbiter: scan-out reader has priority, writer is
// protected from starvation; fixed-length bursts separated by a mandatory idle gap.
module psram_arbiter #(
    parameter int BURST_BEATS = 8,
    parameter int CMD_GAP     = 14,
    parameter int RD_TIMEOUT  = 64,
    parameter int STARVE_MAX  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_calib_done,
    input  logic        i_w_req,
    input  logic [20:0] i_w_addr,
    input  logic [63:0] i_w_data,
    input  logic [7:0]  i_w_mask,
    output logic        o_w_gnt,
    input  logic        i_r_req,
    input  logic [20:0] i_r_addr,
    output logic        o_r_gnt,
    output logic [63:0] o_r_data,
    output logic        o_r_valid,
    output logic        o_cmd,
    output logic        o_cmd_en,
    output logic [20:0] o_addr,
    output logic [63:0] o_wr_data,
    output logic [7:0]  o_data_mask,
    input  logic [63:0] i_rd_data,
    input  logic        i_rd_data_valid,
    output logic        o_busy,
    output logic        o_err
);
    localparam int CNT_MAX = (BURST_BEATS > CMD_GAP) ? BURST_BEATS : CMD_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(RD_TIMEOUT + 1);
    localparam int STV_W   = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(CMD_GAP - 1);
    localparam logic [TMR_W-1:0] LAST_TMR  = TMR_W'(RD_TIMEOUT - 1);
    localparam logic [STV_W-1:0] STV_SAT   = STV_W'(STARVE_MAX);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD, ST_GAP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // shared: write beat, read beat, or gap cycle
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             cmd_q, cmd_d;
    logic             err_q, err_d;
    logic             w_win, w_gnt, r_gnt;

    assign w_win = i_w_req && (!i_r_req || starve_q == STV_SAT);
    assign w_gnt = (state_q == ST_IDLE) && w_win;
    assign r_gnt = (state_q == ST_IDLE) && i_r_req && !w_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            tmr_q    <= '0;
            starve_q <= '0;
            cmd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            starve_q <= starve_d;
            cmd_q    <= cmd_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        starve_d = starve_q;
        cmd_d    = cmd_q;
        err_d    = err_q;
        unique case (state_q)
            ST_INIT: if (i_calib_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (w_gnt) begin
                    starve_d = '0;
                    cmd_d    = 1'b1;
                    // beat 0 is the grant cycle itself
                    state_d  = (BURST_BEATS == 1) ? ST_GAP : ST_WR;
                    cnt_d    = (BURST_BEATS == 1) ? '0 : CNT_W'(1);
                end else if (r_gnt) begin
                    if (!i_w_req)
                        starve_d = '0;
                    else if (starve_q != STV_SAT)
                        starve_d = starve_q + 1'b1;
                    cmd_d   = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = TMR_W'(1);
                    state_d = ST_RD;
                end else if (!i_w_req) begin
                    starve_d = '0;
                end
            end
            ST_WR: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD: begin
                tmr_d = tmr_q + 1'b1;
                if (i_rd_data_valid && cnt_q == LAST_BEAT) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    if (i_rd_data_valid) cnt_d = cnt_q + 1'b1;
                    if (tmr_q == LAST_TMR) begin
                        err_d   = 1'b1;
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        o_w_gnt     = w_gnt;
        o_r_gnt     = r_gnt;
        o_cmd_en    = w_gnt || r_gnt;
        o_cmd       = cmd_q;
        o_addr      = '0;
        o_wr_data   = '0;
        o_data_mask = 8'hFF;
        o_r_data    = '0;
        o_r_valid   = 1'b0;
        o_busy      = (state_q != ST_IDLE);
        o_err       = err_q;
        if (w_gnt) begin
            o_cmd  = 1'b1;
            o_addr = i_w_addr;
        end else if (r_gnt) begin
            o_cmd  = 1'b0;
            o_addr = i_r_addr;
        end
        if (w_gnt || state_q == ST_WR) begin
            o_wr_data   = i_w_data;
            o_data_mask = i_w_mask;
        end
        if (state_q == ST_RD) begin
            o_r_data  = i_rd_data;
            o_r_valid = i_rd_data_valid;
        end
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle numbers.
module tb_psram_arbiter;
    localparam int BB = 8, GAP = 14, TO = 64, SM = 4;

    logic        i_clk = 1'b0, i_rst_n, i_calib_done;
    logic        i_w_req, i_r_req, i_rd_data_valid;
    logic [20:0] i_w_addr, i_r_addr;
    logic [63:0] i_w_data, i_rd_data;
    logic [7:0]  i_w_mask;
    logic        o_w_gnt, o_r_gnt, o_r_valid, o_cmd, o_cmd_en, o_busy, o_err;
    logic [63:0] o_r_data, o_wr_data;
    logic [20:0] o_addr;
    logic [7:0]  o_data_mask;

    psram_arbiter #(.BURST_BEATS(BB), .CMD_GAP(GAP), .RD_TIMEOUT(TO), .STARVE_MAX(SM)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_calib_done(i_calib_done),
        .i_w_req(i_w_req), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_w_mask(i_w_mask),
        .o_w_gnt(o_w_gnt), .i_r_req(i_r_req), .i_r_addr(i_r_addr), .o_r_gnt(o_r_gnt),
        .o_r_data(o_r_data), .o_r_valid(o_r_valid), .o_cmd(o_cmd), .o_cmd_en(o_cmd_en),
        .o_addr(o_addr), .o_wr_data(o_wr_data), .o_data_mask(o_data_mask),
        .i_rd_data(i_rd_data), .i_rd_data_valid(i_rd_data_valid), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int nvec = 0, nmiss = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: the arbiter is free again at a known cycle number; reads close on last beat or timeout.
    bit m_init = 1, m_rd_open = 0, m_err = 0, m_cmd = 0;
    int m_starve = 0, m_free = 0, m_rd_g = 0, m_rd_n = 0, m_wr_g = -1000;

    always @(negedge i_clk) begin
        bit idle, eg_w, eg_r, ebeat, erv;
        if (!i_rst_n) begin
            m_init = 1; m_rd_open = 0; m_err = 0; m_cmd = 0; m_starve = 0; m_wr_g = -1000;
            chk("rst_wgnt", o_w_gnt, 0); chk("rst_rgnt", o_r_gnt, 0);
            chk("rst_cmden", o_cmd_en, 0); chk("rst_cmd", o_cmd, 0);
            chk("rst_rvalid", o_r_valid, 0); chk("rst_err", o_err, 0);
            chk("rst_busy", o_busy, 1); chk("rst_mask", o_data_mask, 8'hFF);
        end else begin
            idle  = !m_init && cyc >= m_free && !m_rd_open;
            eg_w  = idle && i_w_req && (!i_r_req || m_starve == SM);
            eg_r  = idle && i_r_req && !eg_w;
            if (eg_w) m_wr_g = cyc;
            ebeat = (cyc >= m_wr_g) && (cyc < m_wr_g + BB);
            erv   = m_rd_open && i_rd_data_valid;
            chk("wgnt", o_w_gnt, eg_w);
            chk("rgnt", o_r_gnt, eg_r);
            chk("cmden", o_cmd_en, eg_w || eg_r);
            chk("cmd", o_cmd, eg_w ? 1'b1 : eg_r ? 1'b0 : m_cmd);
            chk("busy", o_busy, !idle);
            chk("err", o_err, m_err);
            chk("rvalid", o_r_valid, erv);
            chk("wrdata", o_wr_data, ebeat ? i_w_data : 64'h0);
            chk("mask", o_data_mask, ebeat ? i_w_mask : 8'hFF);
            if (eg_w || eg_r) chk("addr", o_addr, eg_w ? i_w_addr : i_r_addr);
            if (erv) chk("rdata", o_r_data, i_rd_data);
            if (m_init && i_calib_done) begin m_init = 0; m_free = cyc + 1; end
            if (idle && !i_w_req) m_starve = 0;
            if (eg_w) begin m_starve = 0; m_cmd = 1; m_free = cyc + BB + GAP; end
            if (eg_r) begin
                if (i_w_req) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
                m_cmd = 0; m_rd_open = 1; m_rd_g = cyc; m_rd_n = 0;
            end else if (m_rd_open) begin
                if (i_rd_data_valid) m_rd_n++;
                if (m_rd_n == BB) begin m_rd_open = 0; m_free = cyc + 1 + GAP; end
                else if (cyc - m_rd_g == TO - 1) begin m_rd_open = 0; m_err = 1; m_free = cyc + 1 + GAP; end
            end
        end
    end

    // grant log for ordering / latency checks
    byte gk[$];
    int  gc[$];
    always @(negedge i_clk) if (i_rst_n) begin
        if (o_r_gnt) begin gk.push_back("R"); gc.push_back(cyc); end
        if (o_w_gnt) begin gk.push_back("W"); gc.push_back(cyc); end
    end

    // PSRAM controller read-data responder
    int rsp_beats = 8, pend = 0, ph = 0, rseq = 0;
    bit rsp_gap = 0, stray_v = 0;
    initial begin
        i_rd_data_valid = 0; i_rd_data = '0;
        forever begin
            @(negedge i_clk);
            if (o_r_gnt) begin pend = rsp_beats; ph = 0; end
            @(posedge i_clk); #1;
            if (pend > 0 && (!rsp_gap || (ph % 2) == 1)) begin
                i_rd_data_valid = 1;
                i_rd_data = {32'hC0DE0000 + 32'(rseq), 32'(rseq * 7)};
                rseq++; pend--;
            end else begin
                i_rd_data_valid = stray_v;
                i_rd_data = stray_v ? 64'hDEADDEADDEADDEAD : 64'h0;
            end
            ph++;
        end
    end

    task automatic wait_idle(input int lim);
        int n = 0;
        @(negedge i_clk); #1;
        while (o_busy && n < lim) begin @(negedge i_clk); #1; n++; end
        chk("idle_wait", o_busy, 0);
    endtask

    task automatic wait_gnt(input int lim, output int c);
        int n = 0;
        c = -1;
        while (n < lim) begin
            @(negedge i_clk); #1;
            if (o_r_gnt || o_w_gnt) begin c = cyc; break; end
            n++;
        end
        chk("gnt_wait", c >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1);
    end

    logic [7:0] wm [8];
    string exp_ord;
    int n_cal, g, c, nv;

    initial begin
        wm = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        exp_ord = "RRRRWRRRRW";
        i_rst_n = 0; i_calib_done = 0; i_w_req = 0; i_r_req = 0;
        i_w_addr = '0; i_r_addr = '0; i_w_data = '0; i_w_mask = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("por_busy", o_busy, 1); chk("por_mask", o_data_mask, 8'hFF); chk("por_cmden", o_cmd_en, 0);

        // no calibration: both requests held, nothing issued
        @(posedge i_clk); #1;
        i_rst_n = 1; i_r_req = 1; i_w_req = 1; i_r_addr = 21'h1ABCD; i_w_addr = 21'h00020;
        repeat (10) @(posedge i_clk);
        #1;
        chk("nocal_gnts", gk.size(), 0);
        gk.delete(); gc.delete();
        i_calib_done = 1; n_cal = cyc;
        for (int n = 0; n < 400 && gk.size() < 10; n++) begin @(negedge i_clk); #1; end
        @(posedge i_clk); #1;
        i_r_req = 0; i_w_req = 0;
        chk("order_cnt", gk.size(), 10);
        if (gk.size() >= 10) begin
            chk("calib_lat", gc[0], n_cal + 1);
            for (int i = 0; i < 10; i++) chk("order", gk[i], exp_ord[i]);
        end

        // lone write burst with walking-zero masks
        wait_idle(100);
        @(posedge i_clk); #1;
        i_w_addr = 21'h00020; i_w_req = 1; i_w_mask = wm[0]; i_w_data = 64'hA0;
        @(negedge i_clk); #1;
        g = cyc;
        chk("wr_gnt", o_w_gnt, 1); chk("wr_cmd", o_cmd, 1);
        chk("wr_addr", o_addr, 21'h00020); chk("wr_m0", o_data_mask, 8'hFE);
        for (int b = 1; b < 8; b++) begin
            @(posedge i_clk); #1;
            i_w_req = 0; i_w_mask = wm[b]; i_w_data = 64'hA0 + 64'(b);
            @(negedge i_clk); #1;
            chk("wr_mask", o_data_mask, wm[b]);
            chk("wr_data", o_wr_data, 64'hA0 + 64'(b));
        end
        @(posedge i_clk); #1;
        i_w_mask = 8'h00; i_w_data = '1; i_w_req = 1;
        @(negedge i_clk); #1;
        chk("wr_post_mask", o_data_mask, 8'hFF); chk("wr_post_data", o_wr_data, 64'h0);
        wait_gnt(60, c);
        chk("wr_gap", c - g, 22);
        @(posedge i_clk); #1;
        i_w_req = 0;

        // read with gapped beats, then stray valid while idle
        wait_idle(100);
        rsp_gap = 1;
        @(posedge i_clk); #1;
        i_r_addr = 21'h01234; i_r_req = 1;
        wait_gnt(5, g);
        chk("rd_gnt", o_r_gnt, 1); chk("rd_addr", o_addr, 21'h01234); chk("rd_cmd", o_cmd, 0);
        @(posedge i_clk); #1;
        i_r_req = 0;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk); #1;
            if (o_r_valid) nv++;
            if (i == 29) chk("rd_gap_busy", o_busy, 1);
            if (i == 30) chk("rd_gap_end", o_busy, 0);
        end
        chk("rd_beats", nv, 8);
        @(posedge i_clk); #1;
        stray_v = 1;
        for (int i = 0; i < 4; i++) begin @(negedge i_clk); #1; chk("stray_rv", o_r_valid, 0); end
        @(posedge i_clk); #1;
        stray_v = 0; rsp_gap = 0;

        // short read -> timeout
        rsp_beats = 5;
        wait_idle(100);
        @(posedge i_clk); #1;
        i_r_req = 1;
        wait_gnt(5, g);
        @(posedge i_clk); #1;
        i_r_req = 0;
        while (cyc < g + 63) begin @(negedge i_clk); #1; end
        chk("to_err_pre", o_err, 0);
        @(negedge i_clk); #1;
        chk("to_err", o_err, 1); chk("to_busy", o_busy, 1);
        while (cyc < g + 77) begin @(negedge i_clk); #1; end
        chk("to_gap_busy", o_busy, 1);
        @(negedge i_clk); #1;
        chk("to_idle", o_busy, 0);
        rsp_beats = 8;

        // reset during write beat 3
        wait_idle(100);
        @(posedge i_clk); #1;
        i_w_req = 1; i_w_addr = 21'h1F000; i_w_data = 64'h1111; i_w_mask = 8'h0F;
        wait_gnt(5, g);
        for (int b = 1; b <= 3; b++) begin @(posedge i_clk); #1; i_w_req = 0; end
        #1;
        i_rst_n = 0; i_calib_done = 0; i_r_req = 1;
        #1;
        chk("ar_wgnt", o_w_gnt, 0); chk("ar_cmden", o_cmd_en, 0); chk("ar_cmd", o_cmd, 0);
        chk("ar_rvalid", o_r_valid, 0); chk("ar_err", o_err, 0); chk("ar_busy", o_busy, 1);
        chk("ar_mask", o_data_mask, 8'hFF); chk("ar_wdata", o_wr_data, 64'h0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1;
        gk.delete(); gc.delete();
        repeat (8) @(posedge i_clk);
        #1;
        chk("post_rst_nognt", gk.size(), 0);
        i_calib_done = 1; n_cal = cyc;
        wait_gnt(5, c);
        chk("recal_lat", c, n_cal + 1); chk("recal_r", o_r_gnt, 1);
        @(posedge i_clk); #1;
        i_r_req = 0;
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
